stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_pkg.sv | 7 +
 rtl/stack_ctrl_if.sv | 18 +
 rtl/stack_wsel.sv | 10 +
 rtl/stack_ctrl.sv | 71 +++++++
 tb/tb_stack_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared stack geometry and controller state encoding.
package stack_pkg;
  localparam int STACK_DEPTH = 16;
  localparam int STACK_PTR_W = 4;
  localparam int STACK_CNT_W = 5;
  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_e;
endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response bundle between a stack user (master) and stack_ctrl (slave).
interface stack_ctrl_if #(parameter int WIDTH = 8);
  import stack_pkg::*;
  logic push;
  logic pop;
  logic clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic dout_vld;
  logic [STACK_DEPTH-1:0] wr_sel;
  logic [STACK_CNT_W-1:0] count;
  logic empty;
  logic full;
  logic ovf;
  logic unf;
  modport master (output push, pop, clr, din, input dout, dout_vld, wr_sel, count, empty, full, ovf, unf);
  modport slave (input push, pop, clr, din, output dout, dout_vld, wr_sel, count, empty, full, ovf, unf);
endinterface

// File: rtl/stack_wsel.sv
// stack_wsel: 4-to-16 one-hot write-select decoder with enable.
module stack_wsel
  import stack_pkg::*;
(
  input  logic                   en,
  input  logic [STACK_PTR_W-1:0] idx,
  output logic [STACK_DEPTH-1:0] sel
);
  always_comb sel = en ? STACK_DEPTH'(1) << idx : '0;
endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: 16-entry LIFO with push/pop/replace and sticky ovf/unf flags.
// Define STACK_CTRL_ERR_EN to enable ovf/unf/clr; otherwise the flags read 0.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  stack_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [STACK_PTR_W-1:0] sp_q, sp_d, sp_dec, wr_idx;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic dout_vld_q, dout_vld_d, ovf_q, ovf_d, unf_q, unf_d;
  logic is_empty, is_full, push_op, pop_op, rep_op, wr_en;
  always_comb begin
    is_empty = state_q == EMPTY;
    is_full = state_q == FULL;
    sp_dec = sp_q - 1'b1;
    // push with pop on an empty stack degrades to a plain push
    push_op = bus.push & (bus.pop ? is_empty : !is_full);
    pop_op = bus.pop & !bus.push & !is_empty;
    rep_op = bus.push & bus.pop & !is_empty;
    wr_en = push_op | rep_op;
    wr_idx = rep_op ? sp_dec : sp_q;
    sp_d = push_op ? sp_q + 1'b1 : pop_op ? sp_dec : sp_q;
    state_d = push_op ? (sp_q == '1 ? FULL : ACTIVE) :
              pop_op ? (sp_q == STACK_PTR_W'(1) ? EMPTY : ACTIVE) : state_q;
    dout_d = (pop_op | rep_op) ? mem_q[sp_dec] : dout_q;
    dout_vld_d = pop_op | rep_op;
`ifdef STACK_CTRL_ERR_EN
    ovf_d = (bus.push & !bus.pop & is_full) | (ovf_q & !bus.clr);
    unf_d = (bus.pop & is_empty) | (unf_q & !bus.clr);
`else
    ovf_d = 1'b0;
    unf_d = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sp_q <= '0;
      dout_q <= '0;
      dout_vld_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q <= sp_d;
      dout_q <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // storage is not reset; the EMPTY state guarantees stale entries are never read
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (bus.wr_sel[i]) mem_q[i] <= bus.din;
  end
  stack_wsel u_wsel (.en(wr_en), .idx(wr_idx), .sel(bus.wr_sel));
  assign bus.dout = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.count = is_full ? STACK_CNT_W'(STACK_DEPTH) : STACK_CNT_W'(sp_q);
  assign bus.empty = is_empty;
  assign bus.full = is_full;
  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: table vectors, directed corner sequences and random traffic against a queue model.
module tb_stack_ctrl;
  import stack_pkg::*;
`ifdef STACK_CTRL_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct {
    bit push;
    bit pop;
    bit clr;
    logic [7:0] din;
    int cnt;
    logic [7:0] dout;
    bit vld;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  stack_ctrl_if #(.WIDTH(8)) bus ();
  stack_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int vecs = 0;
  int miss = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  bit m_vld = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  vec_t tbl [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_outs();
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.full), 32'(q.size() == 16));
    chk("dout", 32'(bus.dout), 32'(m_dout));
    chk("dout_vld", 32'(bus.dout_vld), 32'(m_vld));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf & ERR));
    chk("unf", 32'(bus.unf), 32'(m_unf & ERR));
  endtask
  task automatic cycle(input bit p, input bit po, input bit c, input logic [7:0] d);
    int n;
    logic [15:0] ws;
    bit so, su;
    bus.push = p;
    bus.pop = po;
    bus.clr = c;
    bus.din = d;
    n = q.size();
    ws = '0;
    so = 1'b0;
    su = 1'b0;
    m_vld = 1'b0;
    if (p && po && n > 0) ws = 16'(1) << (n - 1);
    else if (p && n < 16) ws = 16'(1) << n;
    #1 chk("wr_sel", 32'(bus.wr_sel), 32'(ws));
    @(posedge clk);
    if (p && po && n > 0) begin
      m_dout = q[n-1];
      q[n-1] = d;
      m_vld = 1'b1;
    end else if (p && n < 16) begin
      q.push_back(d);
      su = po;
    end else if (p) so = 1'b1;
    else if (po && n > 0) begin
      m_dout = q.pop_back();
      m_vld = 1'b1;
    end else if (po) su = 1'b1;
    m_ovf = so | (m_ovf & !c);
    m_unf = su | (m_unf & !c);
    #1 check_outs();
  endtask
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    m_dout = 8'h00;
    m_vld = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_vld", 32'(bus.dout_vld), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.clr = 1'b0;
    bus.din = 8'h00;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h33, 3, 8'h00, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h33, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h22, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h11, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'hA5, 1, 8'h11, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'h5A, 1, 8'hA5, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h5A, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h5A, 1'b0};
    #12 check_outs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].din);
      chk("tbl_count", 32'(bus.count), 32'(tbl[i].cnt));
      chk("tbl_dout", 32'(bus.dout), 32'(tbl[i].dout));
      chk("tbl_vld", 32'(bus.dout_vld), 32'(tbl[i].vld));
    end
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
    chk("full16", 32'(bus.full), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 8'hFF);
    chk("ovf17", 32'(bus.ovf), 32'(ERR));
    chk("count17", 32'(bus.count), 32'd16);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pop_full", 32'(bus.dout), 32'h0F);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf_set", 32'(bus.unf), 32'(ERR));
    chk("unf_novld", 32'(bus.dout_vld), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf_clr", 32'(bus.unf), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    chk("unf_prio", 32'(bus.unf), 32'(ERR));
    cycle(1'b1, 1'b1, 1'b1, 8'h77);
    chk("pp_empty_cnt", 32'(bus.count), 32'd1);
    chk("pp_empty_unf", 32'(bus.unf), 32'(ERR));
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_rst_cnt", 32'(bus.count), 32'd7);
    async_reset();
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 150) % 2 == 1) ? 75 : 25;
      cycle(($urandom % 100) < bias, ($urandom % 100) < (100 - bias),
            ($urandom % 8) == 0, 8'($urandom));
      if (i % 1000 == 999) async_reset();
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
